// File: rtl/dl_report_pkg.sv
// Shared encodings for the deadlock cycle reporter.
// Holds FSM states, record kinds and the index-width helper.
package dl_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILTER   = 3'd1,
        ST_DETECTED = 3'd2,
        ST_REPORT   = 3'd3,
        ST_HALT     = 3'd4
    } dl_state_e;

    typedef enum logic [1:0] {
        REC_START   = 2'd0,
        REC_MEMBER  = 2'd1,
        REC_END     = 2'd2,
        REC_SUMMARY = 2'd3
    } rec_kind_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dl_prio_enc.sv
// Lowest-set-bit priority encoder.
// Produces the one-hot of the lowest set bit and its index.
module dl_prio_enc
    import dl_report_pkg::*;
#(
    parameter int PROC_NUM = 4,
    localparam int IDX_W = idx_w(PROC_NUM)
) (
    input  logic [PROC_NUM-1:0] vec,
    output logic [PROC_NUM-1:0] onehot,
    output logic [IDX_W-1:0]    idx
);

    // Scan from the top so the lowest set bit wins last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dl_cycle_reporter.sv
// Deadlock cycle reporter: filters blocked flags, confirms a
// deadlock and streams START/MEMBER/END/SUMMARY records per cycle.
module dl_cycle_reporter
    import dl_report_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int FILTER_CYCLES  = 1000,
    parameter int REPORT_TIMEOUT = 256,
    localparam int IDX_W = idx_w(PROC_NUM)
) (
    input  logic                dl_clock,
    input  logic                dl_reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic                dl_rearm,
    input  logic                rec_ready,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_done,
    output logic                rec_valid,
    output logic [1:0]          rec_kind,
    output logic [IDX_W-1:0]    rec_idx,
    output logic [7:0]          rec_cycle_id
);

    localparam logic [15:0] KEEP_LAST = 16'(FILTER_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(REPORT_TIMEOUT - 1);

    dl_state_e           state_q, state_d;
    logic [PROC_NUM-1:0] detect_q, detect_d;
    logic [PROC_NUM-1:0] done_q, done_d;
    logic [PROC_NUM-1:0] last_vec_q, last_vec_d;
    logic [PROC_NUM-1:0] origin_reg_q, origin_reg_d;
    logic [IDX_W-1:0]    origin_idx_q, origin_idx_d;
    logic [15:0]         keep_cnt_q, keep_cnt_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;
    logic [7:0]          cycle_id_q, cycle_id_d;
    logic                rec_valid_q, rec_valid_d;
    rec_kind_e           rec_kind_q, rec_kind_d;
    logic [IDX_W-1:0]    rec_idx_q, rec_idx_d;
    logic [7:0]          rec_cycle_id_q, rec_cycle_id_d;

    logic                free;
    logic                tmo_hit;
    logic [PROC_NUM-1:0] origin_c;
    logic                token_clear_c;
    logic [PROC_NUM-1:0] sel_oh;
    logic [IDX_W-1:0]    sel_idx;
    logic [PROC_NUM-1:0] mem_oh;
    logic [IDX_W-1:0]    mem_idx;

    dl_prio_enc #(.PROC_NUM(PROC_NUM)) u_sel_enc (
        .vec    (detect_q & ~done_q),
        .onehot (sel_oh),
        .idx    (sel_idx)
    );

    dl_prio_enc #(.PROC_NUM(PROC_NUM)) u_mem_enc (
        .vec    (dl_in_vec),
        .onehot (mem_oh),
        .idx    (mem_idx)
    );

    always_comb begin
        free           = !rec_valid_q || rec_ready;
        tmo_hit        = 1'b0;
        state_d        = state_q;
        detect_d       = detect_q;
        done_d         = done_q;
        last_vec_d     = last_vec_q;
        origin_reg_d   = origin_reg_q;
        origin_idx_d   = origin_idx_q;
        keep_cnt_d     = keep_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        cycle_id_d     = cycle_id_q;
        rec_valid_d    = free ? 1'b0 : rec_valid_q;
        rec_kind_d     = rec_kind_q;
        rec_idx_d      = rec_idx_q;
        rec_cycle_id_d = rec_cycle_id_q;
        origin_c       = '0;
        token_clear_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|dl_in_vec) begin
                    detect_d   = dl_in_vec;
                    keep_cnt_d = '0;
                    state_d    = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (|(detect_q & ~dl_in_vec)) begin
                    keep_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    keep_cnt_d = keep_cnt_q + 16'd1;
                    if (keep_cnt_q == KEEP_LAST) begin
                        state_d = ST_DETECTED;
                    end
                end
            end
            ST_DETECTED: begin
                if (free && (detect_q != done_q)) begin
                    origin_c       = sel_oh;
                    origin_reg_d   = sel_oh;
                    origin_idx_d   = sel_idx;
                    tmo_cnt_d      = '0;
                    rec_valid_d    = 1'b1;
                    rec_kind_d     = REC_START;
                    rec_idx_d      = sel_idx;
                    rec_cycle_id_d = cycle_id_q;
                    state_d        = ST_REPORT;
                end else if (free) begin
                    rec_valid_d    = 1'b1;
                    rec_kind_d     = REC_SUMMARY;
                    rec_idx_d      = '0;
                    rec_cycle_id_d = cycle_id_q - 8'd1;
                    state_d        = ST_HALT;
                end
            end
            ST_REPORT: begin
                // Counter parks at its last value so a stalled END still fires.
                tmo_hit = (tmo_cnt_q >= TMO_LAST);
                if (!tmo_hit) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
                if (free) begin
                    done_d = done_q | (dl_in_vec & detect_q);
                    if (tmo_hit || |(dl_in_vec & origin_reg_q)) begin
                        if (tmo_hit) begin
                            done_d = done_d | origin_reg_q;
                        end
                        token_clear_c  = 1'b1;
                        rec_valid_d    = 1'b1;
                        rec_kind_d     = REC_END;
                        rec_idx_d      = origin_idx_q;
                        rec_cycle_id_d = cycle_id_q;
                        cycle_id_d     = (cycle_id_q == 8'hFF) ?
                                         8'hFF : cycle_id_q + 8'd1;
                        state_d        = ST_DETECTED;
                    end else if (|dl_in_vec && (dl_in_vec != last_vec_q)) begin
                        rec_valid_d    = 1'b1;
                        rec_kind_d     = REC_MEMBER;
                        rec_idx_d      = mem_idx;
                        rec_cycle_id_d = cycle_id_q;
                        last_vec_d     = dl_in_vec;
                    end
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (dl_rearm || dl_reset) begin
            origin_c      = '0;
            token_clear_c = 1'b0;
        end
        if (dl_rearm) begin
            state_d        = ST_IDLE;
            detect_d       = '0;
            done_d         = '0;
            last_vec_d     = '0;
            origin_reg_d   = '0;
            origin_idx_d   = '0;
            keep_cnt_d     = '0;
            tmo_cnt_d      = '0;
            cycle_id_d     = 8'd1;
            rec_valid_d    = 1'b0;
            rec_kind_d     = REC_START;
            rec_idx_d      = '0;
            rec_cycle_id_d = '0;
        end
    end

    always_ff @(posedge dl_clock) begin
        if (dl_reset) begin
            state_q        <= ST_IDLE;
            detect_q       <= '0;
            done_q         <= '0;
            last_vec_q     <= '0;
            origin_reg_q   <= '0;
            origin_idx_q   <= '0;
            keep_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            cycle_id_q     <= 8'd1;
            rec_valid_q    <= 1'b0;
            rec_kind_q     <= REC_START;
            rec_idx_q      <= '0;
            rec_cycle_id_q <= '0;
        end else begin
            state_q        <= state_d;
            detect_q       <= detect_d;
            done_q         <= done_d;
            last_vec_q     <= last_vec_d;
            origin_reg_q   <= origin_reg_d;
            origin_idx_q   <= origin_idx_d;
            keep_cnt_q     <= keep_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            cycle_id_q     <= cycle_id_d;
            rec_valid_q    <= rec_valid_d;
            rec_kind_q     <= rec_kind_d;
            rec_idx_q      <= rec_idx_d;
            rec_cycle_id_q <= rec_cycle_id_d;
        end
    end

    assign dl_detect_out = (state_q == ST_DETECTED) ||
                           (state_q == ST_REPORT) ||
                           (state_q == ST_HALT);
    assign dl_done       = (state_q == ST_HALT);
    assign origin        = origin_c;
    assign token_clear   = token_clear_c;
    assign rec_valid     = rec_valid_q;
    assign rec_kind      = rec_kind_q;
    assign rec_idx       = rec_idx_q;
    assign rec_cycle_id  = rec_cycle_id_q;

endmodule
